bunview_stream: RTL and testbench
=================================

BUNVIEW_STREAM -- requirements
Module: bunview_stream

Interface
REQ-001 SHALL have parameter ISIZE_W, default 64: tensor width.
REQ-002 SHALL have parameter ISIZE_H, default 64: tensor height.
REQ-003 SHALL have parameter ISIZE_FEAT, default 1: feature-map count.
REQ-004 SHALL have parameter BEAT_W, default 64: flat bits per input beat. ISIZE_FEAT*ISIZE_W*ISIZE_H must be an integer multiple of BEAT_W; elaboration error otherwise.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous frame abort.
REQ-008 SHALL have port in_valid_i, input, 1 bit: input beat valid.
REQ-009 SHALL have port in_ready_o, output, 1 bit: input beat accepted when in_valid_i && in_ready_o.
REQ-010 SHALL have port in_data_i, input, BEAT_W bits: flat slice.
REQ-011 SHALL have port in_last_i, input, 1 bit: sender marks final beat of a tensor.
REQ-012 SHALL have port out_valid_o, output, 1 bit: layer_o holds a complete tensor.
REQ-013 SHALL have port out_ready_i, input, 1 bit: consumer takes tensor.
REQ-014 SHALL have port layer_o, output, [ISIZE_FEAT-1:0][ISIZE_W-1:0][ISIZE_H-1:0]: rebuilt 3D tensor.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle framing-error pulse.

Function
REQ-016 SHALL define NBEATS = ISIZE_FEAT*ISIZE_W*ISIZE_H/BEAT_W; beat b carries flat bits [b*BEAT_W +: BEAT_W].
REQ-017 SHALL map flat bit n = k*ISIZE_W*ISIZE_H + i*ISIZE_H + j to layer_o[ISIZE_FEAT-1-k][i][j] (inverse of the 3D-to-1D flatten).
REQ-018 SHALL use FSM states FILL and FULL: FILL->FULL on handshake of beat NBEATS-1; FULL->FILL on out_valid_o && out_ready_i.
REQ-019 SHALL drive in_ready_o=1 only in FILL and out_valid_o=1 only in FULL.
REQ-020 SHALL assert out_valid_o the cycle after the final beat handshake, giving NBEATS+1 cycles per tensor with no stalls.
REQ-021 SHALL hold layer_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-022 SHALL increment the beat counter per handshake and wrap it to 0 on the final beat.
REQ-023 SHALL terminate frames by count, never by in_last_i.
REQ-024 SHALL pulse err_o for one cycle when in_last_i disagrees with (counter==NBEATS-1) on an accepted beat.
REQ-025 SHALL, on clear_i, go to FILL with counter 0 and out_valid_o 0 next cycle, leaving buffer contents unchanged; clear_i wins over any same-cycle handshake.
REQ-026 SHALL not update state when in_valid_i=0 in FILL.

Reset
REQ-027 SHALL, while rst_ni=0, asynchronously force state FILL, counter 0, layer_o all 0, out_valid_o 0, err_o 0, in_ready_o 1.

Configuration
REQ-028 SHALL, with BUNVIEW_PINGPONG_EN defined, use two tensor buffers: filling continues into the idle buffer while the other is presented; in_ready_o=0 only when both are full; the output handshake and the final beat in the same cycle are both honoured; tensors are presented in arrival order.
REQ-029 SHALL, without BUNVIEW_PINGPONG_EN, implement the single-buffer behaviour of REQ-018..REQ-020 exactly.

Structure
REQ-030 SHALL place the FILL/FULL state enum typedef and a beat-counter width function ($clog2(NBEATS), minimum 1) in shared package bview_pkg.
REQ-031 SHALL implement one tensor buffer with beat-indexed write enable as sub-module bunview_buf, instantiated once, or twice under BUNVIEW_PINGPONG_EN.

Verification (ISIZE_W=2, ISIZE_H=2, ISIZE_FEAT=2, BEAT_W=4, NBEATS=2)
REQ-032 SHALL check: beats 4'b1010 then 4'b0011 with in_last_i on the second -> next cycle out_valid_o=1, layer_o=8'b1010_0011, err_o never set.
REQ-033 SHALL check: out_ready_i=0 for 5 cycles after the above -> layer_o and out_valid_o stable, in_ready_o=0 (single buffer).
REQ-034 SHALL check: in_last_i=1 on beat 0 -> err_o pulses once, frame still completes after beat 1.
REQ-035 SHALL check: clear_i after one beat -> counter 0, a fresh 2-beat frame decodes correctly.
REQ-036 SHALL check: rst_ni=0 mid-frame -> outputs return to reset values immediately, without waiting for a clock edge.
REQ-037 SHALL check, with BUNVIEW_PINGPONG_EN: 3 back-to-back frames, out_ready_i=1 -> in_ready_o stays 1 and tensors appear in order.

Source files
------------

// File: rtl/bview_pkg.sv
// Shared types and helpers for the bunview_stream slice: FILL/FULL state
// encoding and the beat-counter width function.
package bview_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned nbeats);
        return (nbeats <= 2) ? 1 : $clog2(nbeats);
    endfunction

endpackage

// File: rtl/bunview_buf.sv
// One tensor buffer holding the flat bit vector; each beat lands in the
// slot selected by the beat index when the write enable is high.
module bunview_buf
    import bview_pkg::*;
#(
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned NBEATS = 64,
    parameter int unsigned CNT_W  = cnt_width(NBEATS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [CNT_W-1:0]         idx_i,
    input  logic [BEAT_W-1:0]        data_i,
    output logic [NBEATS*BEAT_W-1:0] flat_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flat_o <= '0;
        end else if (we_i) begin
            for (int unsigned b = 0; b < NBEATS; b++) begin
                if (idx_i == CNT_W'(b)) flat_o[b*BEAT_W +: BEAT_W] <= data_i;
            end
        end
    end

endmodule

// File: rtl/bunview_stream.sv
// Rebuilds a 3D tensor from a stream of flat beats (frames end by count).
// Define BUNVIEW_PINGPONG_EN for two buffers: fill one while presenting the other.
module bunview_stream
    import bview_pkg::*;
#(
    parameter int unsigned ISIZE_W    = 64,
    parameter int unsigned ISIZE_H    = 64,
    parameter int unsigned ISIZE_FEAT = 1,
    parameter int unsigned BEAT_W     = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          clear_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic [BEAT_W-1:0]                             in_data_i,
    input  logic                                          in_last_i,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [ISIZE_FEAT-1:0][ISIZE_W-1:0][ISIZE_H-1:0] layer_o,
    output logic                                          err_o
);

    localparam int unsigned PLANE  = ISIZE_W * ISIZE_H;
    localparam int unsigned TOTAL  = ISIZE_FEAT * PLANE;
    localparam int unsigned NBEATS = TOTAL / BEAT_W;
    localparam int unsigned CNT_W  = cnt_width(NBEATS);

    if (TOTAL % BEAT_W != 0) begin : g_bad_beat_w
        $error("tensor size must be an integer multiple of BEAT_W");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             last_beat, hs_in, hs_out, accept;
    logic [TOTAL-1:0] flat_sel;

    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
    assign hs_in     = in_valid_i && in_ready_o;
    assign hs_out    = out_valid_o && out_ready_i;
    assign accept    = hs_in && !clear_i;

`ifdef BUNVIEW_PINGPONG_EN
    state_t           st_q [2];
    state_t           st_d [2];
    logic             wr_q, wr_d, rd_q, rd_d;
    logic [1:0]       we_v;
    logic [TOTAL-1:0] flat [2];

    // The write buffer is always the idle one, so it is only FULL when both are.
    assign in_ready_o  = (st_q[wr_q] == FILL);
    assign out_valid_o = (st_q[rd_q] == FULL);
    assign flat_sel    = rd_q ? flat[1] : flat[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q[0] <= FILL;
            st_q[1] <= FILL;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            st_q <= st_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_comb begin
        st_d = st_q;
        wr_d = wr_q;
        rd_d = rd_q;
        we_v = '0;
        if (clear_i) begin
            st_d[0] = FILL;
            st_d[1] = FILL;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
        end else begin
            if (hs_out) begin
                st_d[rd_q] = FILL;
                rd_d       = ~rd_q;
            end
            if (hs_in) begin
                we_v[wr_q] = 1'b1;
                if (last_beat) begin
                    st_d[wr_q] = FULL;
                    wr_d       = ~wr_q;
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        bunview_buf #(.BEAT_W(BEAT_W), .NBEATS(NBEATS), .CNT_W(CNT_W)) u_buf (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .we_i   (we_v[g]),
            .idx_i  (cnt_q),
            .data_i (in_data_i),
            .flat_o (flat[g])
        );
    end
`else
    state_t state_q, state_d;
    logic   we;

    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        if (clear_i) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: if (hs_in) begin
                    we = 1'b1;
                    if (last_beat) state_d = FULL;
                end
                FULL: if (out_ready_i) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    bunview_buf #(.BEAT_W(BEAT_W), .NBEATS(NBEATS), .CNT_W(CNT_W)) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (we),
        .idx_i  (cnt_q),
        .data_i (in_data_i),
        .flat_o (flat_sel)
    );
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (accept) cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end

    assign err_d = accept && (in_last_i != last_beat);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_o <= err_d;
        end
    end

    // Feature map k of the flat stream is placed at layer index FEAT-1-k.
    always_comb begin
        layer_o = '0;
        for (int unsigned k = 0; k < ISIZE_FEAT; k++) begin
            layer_o[ISIZE_FEAT-1-k] = flat_sel[k*PLANE +: PLANE];
        end
    end

endmodule

// File: tb/tb_bunview_stream.sv
// Scoreboard bench for bunview_stream (2x2x2 tensor, 4-bit beats);
// define BUNVIEW_PINGPONG_EN to exercise the two-buffer build.
module tb_bunview_stream;

    localparam int W   = 2;
    localparam int H   = 2;
    localparam int F   = 2;
    localparam int BW  = 4;
    localparam int NB  = 2;
    localparam int TOT = F * W * H;
`ifdef BUNVIEW_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n, clear, in_valid, in_ready, in_last, out_valid, out_ready, err;
    logic [BW-1:0] in_data;
    logic [F-1:0][W-1:0][H-1:0] layer;

    always #5 clk = ~clk;

    bunview_stream #(.ISIZE_W(W), .ISIZE_H(H), .ISIZE_FEAT(F), .BEAT_W(BW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .layer_o     (layer),
        .err_o       (err)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tensors the DUT should be holding, in arrival order.
    logic [TOT-1:0] exp_q[$];
    logic [TOT-1:0] frame;
    int             beat;
    logic           err_exp;

    function automatic logic [TOT-1:0] rebuild(input logic [TOT-1:0] flat);
        logic [F-1:0][W-1:0][H-1:0] t;
        for (int k = 0; k < F; k++)
            for (int i = 0; i < W; i++)
                for (int j = 0; j < H; j++)
                    t[F-1-k][i][j] = flat[k*W*H + i*H + j];
        return t;
    endfunction

    always @(negedge clk) begin
        logic acc, pop;
        if (!rst_n) begin
            exp_q.delete();
            beat    = 0;
            frame   = '0;
            err_exp = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < CAP));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("err", 32'(err), 32'(err_exp));
            if (exp_q.size() > 0) chk("layer", 32'(layer), 32'(exp_q[0]));
            acc     = in_valid && (exp_q.size() < CAP);
            pop     = out_ready && (exp_q.size() > 0);
            err_exp = 1'b0;
            if (clear) begin
                exp_q.delete();
                beat = 0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) begin
                    err_exp = (in_last != (beat == NB - 1));
                    frame[beat*BW +: BW] = in_data;
                    if (beat == NB - 1) begin
                        exp_q.push_back(rebuild(frame));
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [BW-1:0] d, input logic l,
                       input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_chk;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_layer", 32'(layer), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_layer", 32'(layer), 32'd0);

        // Known frame, then a 5-cycle stall.
        cyc(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        chk("frame_valid", 32'(out_valid), 32'd1);
        chk("frame_layer", 32'(layer), 32'b1010_0011);
        repeat (5) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_layer", 32'(layer), 32'b1010_0011);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Early in_last on beat 0.
        cyc(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Clear after one beat, clear against a valid beat, then a fresh frame.
        cyc(1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h5, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'hE, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset with a tensor held, then mid-frame.
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        async_reset_chk();
        cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        async_reset_chk();
        cyc(1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'hB, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

`ifdef BUNVIEW_PINGPONG_EN
        // Back-to-back frames with the consumer always ready.
        for (int f = 0; f < 3; f++) begin
            cyc(1'b1, 4'($urandom), 1'b0, 1'b1, 1'b0);
            chk("pp_in_ready", 32'(in_ready), 32'd1);
            cyc(1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0);
            chk("pp_in_ready", 32'(in_ready), 32'd1);
        end
        repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomised traffic with occasional framing errors and clears.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, 4'($urandom),
                (beat == NB - 1) ^ (($urandom % 10) == 0),
                ($urandom % 3) != 0, ($urandom % 30) == 0);
        end
        repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
